inverse_comb_filter: RTL and testbench
======================================

# inverse_comb_filter

Feedforward (FIR) comb filter computing y[n] = x[n] − g·x[n−τ] on a fixed-point sample stream; the exact inverse of the feedback comb in the reverb path. It is used to undo or pre-emphasise comb colouration and in the closed-loop comb test harness. The block runs on the system clock and processes one sample per `sample_valid` strobe. It owns its delay line in block RAM, with an internal pointer/fill FSM.

## Interface
- `WIDTH`, 24, integer bits of a sample word; word size WORD = WIDTH + `FIXED_POINT`.
- `MAXDELAY`, 4096, delay-line depth in samples; power of two.
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe; `in`, `tau` and `gain` are valid on this cycle.
- `in`  in  WORD signed  input sample x[n].
- `tau`  in  WORD signed  delay in samples, integer part only (fraction bits ignored).
- `gain`  in  WORD signed  g, fixed point with `FIXED_POINT` fraction bits.
- `out`  out  WORD signed  y[n]; holds its value until the next result.
- `out_valid`  out  1  one-cycle pulse when `out` updates.
- `busy`  out  1  high while a sample is in flight.
- `overrun`  out  1  sticky flag; set when `sample_valid` arrives while `busy`.

## Operation
- FSM states: IDLE, READ, WAIT, CALC, WRITE.
- IDLE with `sample_valid` high:
  - Latch x, g and τ.
  - Clamp τ to [1, MAXDELAY]; τ ≤ 0 becomes 1.
  - Go to READ.
- READ: issue a BRAM read at address (wr_ptr − τ) mod MAXDELAY.
- WAIT: one cycle of BRAM read latency.
- CALC:
  - d = read data if fill ≥ τ, else 0. BRAM contents are never reset, so stale data must not leak.
  - p = (g·d), full 2·WORD signed product, arithmetic shift right by `FIXED_POINT`, truncated to WORD.
  - y = x − p, computed in WORD+1 bits, then wrapped to WORD (default build).
- WRITE:
  - Write x at wr_ptr.
  - wr_ptr increments modulo MAXDELAY.
  - fill increments, saturating at MAXDELAY.
  - Register y to `out` and pulse `out_valid`.
  - Return to IDLE.
- The read always precedes the write, so τ = MAXDELAY reads the slot about to be overwritten, which is valid.
- `sample_valid` in any state other than IDLE: the sample is dropped, `overrun` is set, and the pipeline is unaffected.
- `tau` and `gain` are sampled per strobe, so a change takes effect on the next accepted sample. Reducing τ never reads unwritten data because of the fill check.

## Timing
- Strobe accepted at cycle 0 → `out_valid` high at cycle 4 (READ at 1, WAIT at 2, CALC at 3, WRITE/output at 4).
- `busy` is high during cycles 1–4.
- Throughput: one sample per 5 clocks minimum. A strobe at cycle 5 or later is accepted.
- Reset values: `out` = 0, `out_valid` = 0, `busy` = 0, `overrun` = 0; wr_ptr = 0, fill = 0, FSM = IDLE.
- Reset asserted mid-sample aborts it: no `out_valid` and no BRAM write.
  - A BRAM write in the reset cycle is inhibited by gating the write enable with FSM == WRITE.

## Configuration
- `INVERSE_COMB_SATURATE_EN`:
  - Defined: the WORD+1-bit difference is clamped to [−2^(WORD−1), 2^(WORD−1)−1].
  - Undefined: the difference is two's-complement wrapped to WORD.
- Latency and all other behaviour are identical in both builds.

## Structure
- The shared package `filter_pkg` holds:
  - WORD-derived types: `sample_t`, `coef_t`, `product_t`.
  - The `FIXED_POINT` constant, mirrored from constants.svh.
  - The FSM state enum `icomb_state_e`.
  - A saturate/wrap function used by both build variants.
- One sub-module, `delay_ram`: a simple dual-port BRAM (WORD × MAXDELAY, one write port, one synchronous read port with 1-cycle latency, no reset on contents).
- Pointer, fill and FSM logic live in the top module.

## Test plan
In the values below, 1.0 = 1<<`FIXED_POINT`.

1. Reset, τ = 3, g = 0.5, impulse x = [1.0, 0, 0, 0, 0] → y = [1.0, 0, 0, −0.5, 0], each `out_valid` exactly 4 cycles after its strobe.
2. After reset, τ = 5, constant x = 2.0 for 8 samples, g = 1.0 → y = 2.0 for samples 0–4, then 0 (fill gating verified).
3. τ = 0 and τ = MAXDELAY+10 → behave as τ = 1 and τ = MAXDELAY respectively; τ = MAXDELAY impulse reappears as −g at sample MAXDELAY (pointer wrap).
4. Strobe at cycles 0 and 2 → second sample dropped, `overrun` = 1 and stays set; only one `out_valid`.
5. x = max positive, τ = 1, prior sample = max negative, g = 1.0 → wrapped result without the macro; max positive with `INVERSE_COMB_SATURATE_EN`.
6. Assert `rstn` during WAIT → no `out_valid`; the next impulse after release sees d = 0.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the comb-filter family.
//   FIXED_POINT    : fraction bits of every sample/coefficient word
//                    (mirrors the value in constants.svh)
//   SAMPLE_WIDTH   : integer bits of a sample word
//   WORD           : full word size (SAMPLE_WIDTH + FIXED_POINT)
//   sample_t, coef_t, product_t, diff_t : WORD-derived signed types
//   icomb_state_e  : inverse comb FSM states
//   sat_wrap()     : clamp or wrap a WORD+1-bit difference to WORD
package filter_pkg;

  localparam int FIXED_POINT  = 8;
  localparam int SAMPLE_WIDTH = 24;
  localparam int WORD         = SAMPLE_WIDTH + FIXED_POINT;

  typedef logic signed [WORD-1:0]   sample_t;
  typedef logic signed [WORD-1:0]   coef_t;
  typedef logic signed [2*WORD-1:0] product_t;
  typedef logic signed [WORD:0]     diff_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CALC,
    WRITE
  } icomb_state_e;

  // Overflow is detected by the two top bits of the WORD+1-bit value
  // disagreeing; without saturation the low WORD bits are the wrapped result.
  function automatic sample_t sat_wrap(input diff_t d, input logic saturate);
    sample_t r;
    r = d[WORD-1:0];
    if (saturate && (d[WORD] != d[WORD-1])) begin
      r = d[WORD] ? {1'b1, {(WORD-1){1'b0}}} : {1'b0, {(WORD-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/inverse_comb_filter_delay_ram.sv
// delay_ram: simple dual-port block RAM used as the comb delay line.
//   clk     : clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   re      : read enable
//   rd_addr : read address
//   rd_data : registered read data, valid one cycle after re
// Contents are deliberately not reset so the array maps onto BRAM.
module delay_ram
  import filter_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  sample_t                  wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output sample_t                  rd_data
);

  sample_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inverse_comb_filter.sv
// inverse_comb_filter: feedforward comb y[n] = x[n] - g * x[n - tau].
//   clk          : system clock
//   rstn         : asynchronous active-low reset
//   sample_valid : one-cycle strobe qualifying in/tau/gain
//   in           : input sample x[n]
//   tau          : delay in samples (integer part used, clamped to [1, MAXDELAY])
//   gain         : coefficient g with FIXED_POINT fraction bits
//   out          : y[n], held until the next result
//   out_valid    : one-cycle pulse when out updates
//   busy         : a sample is in flight
//   overrun      : sticky, a strobe arrived while busy
// Build option: INVERSE_COMB_SATURATE_EN clamps the difference instead of
// wrapping it. Latency is 4 cycles from strobe to out_valid in both builds.
module inverse_comb_filter
  import filter_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_WIDTH,
  parameter int MAXDELAY = 4096
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                sample_valid,
  input  logic signed [WIDTH+FIXED_POINT-1:0] in,
  input  logic signed [WIDTH+FIXED_POINT-1:0] tau,
  input  logic signed [WIDTH+FIXED_POINT-1:0] gain,
  output logic signed [WIDTH+FIXED_POINT-1:0] out,
  output logic                                out_valid,
  output logic                                busy,
  output logic                                overrun
);

  localparam int AW = $clog2(MAXDELAY);
  localparam int FW = AW + 1;

`ifdef INVERSE_COMB_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  icomb_state_e state, state_next;

  logic [AW-1:0] wr_ptr;
  logic [FW-1:0] fill;
  logic [FW-1:0] tau_q;
  logic [FW-1:0] tau_clamped;
  sample_t       x_q;
  coef_t         g_q;
  sample_t       rd_data;
  sample_t       tau_int;
  sample_t       d;
  sample_t       p;
  sample_t       y_calc;
  logic [AW-1:0] rd_addr;
  logic          ram_re;
  logic          ram_we;

  // Integer part of tau, clamped to the usable delay range.
  always_comb begin
    tau_int     = tau >>> FIXED_POINT;
    tau_clamped = FW'(1);
    if (tau_int >= MAXDELAY) begin
      tau_clamped = FW'(MAXDELAY);
    end else if (tau_int > 0) begin
      tau_clamped = FW'(tau_int);
    end
  end

  // tau == MAXDELAY has zero low bits, so it addresses the slot that WRITE
  // is about to overwrite; the read happens first, so this is the oldest sample.
  assign rd_addr = wr_ptr - tau_q[AW-1:0];
  assign ram_re  = (state == READ);
  // Gating on WRITE keeps an aborted sample out of the delay line.
  assign ram_we  = (state == WRITE);

  delay_ram #(.DEPTH(MAXDELAY)) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (x_q),
    .re      (ram_re),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // RAM contents survive reset, so any slot not yet written since reset is
  // masked to zero by the fill count.
  always_comb begin
    d      = (fill >= tau_q) ? rd_data : '0;
    p      = sample_t'((product_t'(g_q) * product_t'(d)) >>> FIXED_POINT);
    y_calc = sat_wrap(diff_t'(x_q) - diff_t'(p), SAT_EN);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (sample_valid) state_next = READ;
      READ:    state_next = WAIT;
      WAIT:    state_next = CALC;
      CALC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q       <= '0;
      g_q       <= '0;
      tau_q     <= FW'(1);
      wr_ptr    <= '0;
      fill      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state == IDLE && sample_valid) begin
        x_q   <= in;
        g_q   <= gain;
        tau_q <= tau_clamped;
      end
      if (state != IDLE && sample_valid) begin
        overrun <= 1'b1;
      end
      // Result is registered at the CALC->WRITE edge so out_valid is high
      // during the WRITE cycle, four cycles after the strobe.
      out_valid <= (state == CALC);
      if (state == CALC) begin
        out <= y_calc;
      end
      if (state == WRITE) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (fill != FW'(MAXDELAY)) begin
          fill <= fill + FW'(1);
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_inverse_comb_filter.sv
module tb_inverse_comb_filter;
  import filter_pkg::*;

  localparam int MAXD = 4096;
  localparam int ONE  = 1 << FIXED_POINT;
  localparam int HALF = ONE / 2;

  logic    clk = 1'b0;
  logic    rstn = 1'b0;
  logic    sample_valid = 1'b0;
  sample_t in_s = '0;
  sample_t tau_s = '0;
  sample_t gain_s = '0;
  sample_t out_s;
  logic    out_valid;
  logic    busy;
  logic    overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inverse_comb_filter #(.WIDTH(SAMPLE_WIDTH), .MAXDELAY(MAXD)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sample_valid (sample_valid),
    .in           (in_s),
    .tau          (tau_s),
    .gain         (gain_s),
    .out          (out_s),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input sample_t obs, input sample_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Strobe one sample and wait (bounded) for its result; lat = -1 on timeout.
  task automatic send(input sample_t x, input sample_t t, input sample_t g,
                      output sample_t y, output int lat, output logic bsy);
    in_s = x;
    tau_s = t;
    gain_s = g;
    sample_valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sample_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
    y = out_s;
    bsy = busy;
    tick();
  endtask

  task automatic sample_chk(input string tag, input sample_t x, input sample_t t,
                            input sample_t g, input sample_t y_exp);
    sample_t y;
    int      lat;
    logic    bsy;
    send(x, t, g, y, lat, bsy);
    check({tag, "_y"}, y, y_exp);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_busy"}, sample_t'(bsy), 1);
  endtask

  initial begin : stim
    sample_t y;
    int      lat;
    logic    bsy;
    int      pulses;
    sample_t seen;
    sample_t wrap_exp;

    // Reset values
    rstn = 1'b0;
    tick();
    check("rst_out", out_s, 0);
    check("rst_out_valid", sample_t'(out_valid), 0);
    check("rst_busy", sample_t'(busy), 0);
    check("rst_overrun", sample_t'(overrun), 0);
    rstn = 1'b1;
    tick();

    // 1: impulse, tau=3, g=0.5
    sample_chk("t1_s0", ONE, 3 * ONE, HALF, ONE);
    sample_chk("t1_s1", 0,   3 * ONE, HALF, 0);
    sample_chk("t1_s2", 0,   3 * ONE, HALF, 0);
    sample_chk("t1_s3", 0,   3 * ONE, HALF, -HALF);
    sample_chk("t1_s4", 0,   3 * ONE, HALF, 0);
    check("t1_busy_idle", sample_t'(busy), 0);
    check("t1_no_overrun", sample_t'(overrun), 0);

    // 2: constant 2.0, tau=5, g=1.0: fill gating for the first five
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sample_chk($sformatf("t2_s%0d", i), 2 * ONE, 5 * ONE, ONE, (i < 5) ? 2 * ONE : 0);
    end

    // 3a: tau=0 and negative tau both act as 1
    do_reset();
    sample_chk("t3_tau0_s0", ONE, 0, HALF, ONE);
    sample_chk("t3_tau0_s1", 0,   0, HALF, -HALF);
    sample_chk("t3_neg_s2",  ONE, -2 * ONE, ONE, ONE);
    sample_chk("t3_neg_s3",  0,   -ONE,     ONE, -ONE);

    // 3b: tau beyond MAXDELAY clamps; impulse returns at sample MAXDELAY
    do_reset();
    sample_chk("t3_big_s0", ONE, (MAXD + 10) * ONE, ONE, ONE);
    for (int i = 1; i <= MAXD + 1; i++) begin
      send(0, (MAXD + 10) * ONE, ONE, y, lat, bsy);
      check($sformatf("t3_big_s%0d", i), y, (i == MAXD) ? -ONE : 0);
      if (i == MAXD) check("t3_big_lat", lat, 4);
    end

    // 4: strobe at cycles 0 and 2 -> second dropped, overrun sticky
    do_reset();
    in_s = 3 * ONE;
    tau_s = ONE;
    gain_s = 0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    in_s = 5 * ONE;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("t4_overrun_set", sample_t'(overrun), 1);
    pulses = 0;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        pulses++;
        seen = out_s;
      end
      tick();
    end
    check("t4_pulses", pulses, 1);
    check("t4_out", seen, 3 * ONE);
    sample_chk("t4_next", ONE, ONE, 0, ONE);
    check("t4_overrun_sticky", sample_t'(overrun), 1);

    // 5: max positive minus max negative with g=1.0
    do_reset();
    sample_chk("t5_s0", 32'sh8000_0000, ONE, ONE, 32'sh8000_0000);
`ifdef INVERSE_COMB_SATURATE_EN
    wrap_exp = 32'sh7FFF_FFFF;
`else
    wrap_exp = 32'shFFFF_FFFF;
`endif
    sample_chk("t5_s1", 32'sh7FFF_FFFF, ONE, ONE, wrap_exp);

    // 6: reset during WAIT aborts the sample
    do_reset();
    in_s = 77 * ONE;
    tau_s = ONE;
    gain_s = ONE;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    check("t6_busy_in_wait", sample_t'(busy), 1);
    rstn = 1'b0;
    #1;
    check("t6_busy_reset", sample_t'(busy), 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rstn = 1'b1;
      tick();
      if (out_valid) pulses++;
    end
    check("t6_no_out_valid", pulses, 0);
    check("t6_out_reset", out_s, 0);
    sample_chk("t6_s0", ONE, ONE, ONE, ONE);
    sample_chk("t6_s1", 0,   ONE, ONE, -ONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
